// File: rtl/reset_pkg.sv
// Shared types and constants for the subsystem reset sequencer.
package reset_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  // Counter width large enough to hold the larger of the two reload values.
  function automatic int unsigned cnt_width(input int unsigned pulse, input int unsigned delay);
    int unsigned m;
    m = (pulse > delay) ? pulse : delay;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/req_sync.sv
// Two-flop level synchronizer for asynchronous reset requests.
module req_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Merges POR, software and watchdog resets into one event, holds it for a
// minimum pulse, then releases per-domain active-low resets in order.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 3,
  parameter int unsigned PULSE_CYCLES = 16,
  parameter int unsigned STAGE_DELAY  = 8
) (
  input  logic                  i_aclk,
  input  logic                  i_rst,
  input  logic                  i_sw_rst_req,
  input  logic                  i_wdt_rst_req,
  output logic [NUM_STAGES-1:0] o_stage_rst_n,
  output logic                  o_rst_done,
  output logic [1:0]            o_rst_cause
);

  localparam int unsigned CW = cnt_width(PULSE_CYCLES, STAGE_DELAY);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(STAGE_DELAY - 1);

  logic sw_sync;
  logic wdt_sync;
  logic req;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic [NUM_STAGES-1:0] stage_next;
  logic                  done_next;
  logic [1:0]            cause_next;
  logic                  last_stage;

  req_sync u_sw_sync (
    .clk (i_aclk),
    .rst (i_rst),
    .d   (i_sw_rst_req),
    .q   (sw_sync)
  );

  req_sync u_wdt_sync (
    .clk (i_aclk),
    .rst (i_rst),
    .d   (i_wdt_rst_req),
    .q   (wdt_sync)
  );

  assign req        = sw_sync | wdt_sync;
  assign last_stage = o_stage_rst_n[NUM_STAGES-1];

  // State and registered outputs.
  always_ff @(posedge i_aclk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ASSERT;
      cnt           <= PULSE_LOAD;
      o_stage_rst_n <= '0;
      o_rst_done    <= 1'b0;
      o_rst_cause   <= CAUSE_POR;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      o_stage_rst_n <= stage_next;
      o_rst_done    <= done_next;
      o_rst_cause   <= cause_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ASSERT: begin
        if (!req && cnt == '0) state_next = RELEASE;
      end
      RELEASE: begin
        if (req)                           state_next = ASSERT;
        else if (cnt == '0 && last_stage)  state_next = DONE;
      end
      DONE: begin
        if (req) state_next = ASSERT;
      end
      default: state_next = ASSERT;
    endcase
  end

  // Counter and next values for the registered outputs.
  always_comb begin
    cnt_next   = cnt;
    stage_next = o_stage_rst_n;
    done_next  = o_rst_done;
    cause_next = o_rst_cause;
    case (state)
      ASSERT: begin
        stage_next = '0;
        done_next  = 1'b0;
        if (req) begin
          cnt_next = PULSE_LOAD;
        end else if (cnt == '0) begin
          stage_next = NUM_STAGES'(1);
          cnt_next   = DELAY_LOAD;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      RELEASE, DONE: begin
        if (req) begin
          // Entering ASSERT: drop everything and record who asked.
          stage_next = '0;
          done_next  = 1'b0;
          cnt_next   = PULSE_LOAD;
          cause_next = wdt_sync ? CAUSE_WDT : CAUSE_SW;
        end else if (state == RELEASE) begin
          if (cnt == '0) begin
            if (last_stage) begin
              done_next = 1'b1;
            end else begin
              stage_next = NUM_STAGES'({o_stage_rst_n, 1'b1});
              cnt_next   = DELAY_LOAD;
            end
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
      end
      default: begin
        stage_next = '0;
        done_next  = 1'b0;
        cnt_next   = PULSE_LOAD;
      end
    endcase
  end

endmodule
